duty_step_ctrl: RTL and testbench
=================================

# duty_step_ctrl

Sequencing controller between the button debouncers and the PWM generator. It turns debounced up/down button levels into single duty-cycle steps with press-and-hold auto-repeat, and arbitrates conflicting presses. It holds a shadow duty value and commits it to the PWM only at a PWM period boundary, so the output never glitches mid-period.

## Interface
- MAX_DUTY, 100: upper duty bound; duty range is 0..MAX_DUTY.
- HOLD_DLY, 50_000_000: sys_clk cycles from the first step to the first auto-repeat step.
- REPEAT_INT, 10_000_000: sys_clk cycles between auto-repeat steps.
- INIT_DUTY, 50: reset value of the shadow and committed duty.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- db_up  in  1  debounced up-button level, synchronous to sys_clk.
- db_down  in  1  debounced down-button level, synchronous to sys_clk.
- period_end  in  1  one-cycle pulse from the PWM counter on its last cycle of a period.
- duty  out  7  committed duty, fed to the PWM comparator.
- duty_shadow  out  7  most recent requested duty.
- pending  out  1  high while duty_shadow has not yet been committed.
- step_up  out  1  one-cycle pulse for each accepted up step.
- step_down  out  1  one-cycle pulse for each accepted down step.

## Operation
- Reset values: duty = duty_shadow = INIT_DUTY; pending, step_up and step_down are 0; FSM is in IDLE; input registers are 0; the timer is 0.
- Edge detect: db_up_q and db_down_q are registered copies of the inputs. A rise is `db_x & ~db_x_q`.
- FSM states and transitions:
  - IDLE: an up-only rise issues an up step and moves to HOLD. A down-only rise issues a down step and moves to HOLD. Rises on both inputs in the same cycle move to LOCK with no step.
  - HOLD: the timer counts. When the held button releases, go to IDLE. When the other button rises, go to LOCK. When timer == HOLD_DLY-1, issue a step in the held direction, clear the timer and go to REPEAT.
  - REPEAT: same as HOLD, but uses REPEAT_INT-1 and stays in REPEAT.
  - LOCK: no steps. Go to IDLE when db_up and db_down are both 0.
- The held direction is latched on entry to HOLD.
- Step arithmetic is 7-bit unsigned. Up from MAX_DUTY and down from 0 follow the Configuration section.
- A step at a bound that results in no change (saturate mode) still pulses step_x but leaves pending unchanged.
- Commit: on period_end, duty <= duty_shadow (the value before any same-cycle step).
- pending is set by a step that changes duty_shadow and cleared by period_end. If a changing step and period_end occur in the same cycle, pending stays 1.
- The timer is $clog2(max(HOLD_DLY, REPEAT_INT)) bits wide and is cleared on every state change.

## Timing
- A rise seen in cycle N gives step_x, the updated duty_shadow and pending all high/visible in cycle N+1.
- Second step: HOLD_DLY cycles after the first. Later steps: every REPEAT_INT cycles.
- A release in cycle N means no step in N+1 or later. The FSM is in IDLE at N+1.
- duty changes only in the cycle after period_end. Latency from a step to the committed duty is at most one PWM period.
- Reset asserted mid-operation immediately returns all state to the reset values. It does not wait for a clock.

## Configuration
- DUTY_WRAP_EN defined: up from MAX_DUTY gives 0; down from 0 gives MAX_DUTY. This applies to auto-repeat as well.
- DUTY_WRAP_EN undefined: saturate, so up at MAX_DUTY and down at 0 leave duty_shadow unchanged.

## Test plan
All scenarios use HOLD_DLY=8, REPEAT_INT=3, INIT_DUTY=50.
- Tap db_up high for 4 cycles, then low: exactly one step_up pulse; duty_shadow=51; pending=1; duty stays 50 until the next period_end, then duty=51 and pending=0.
- Hold db_down for 20 cycles: steps at +1, +9, +12, +15, +18 relative to the rise; duty_shadow=45; no step after release.
- Raise db_up and db_down in the same cycle, hold 10 cycles, release both: no step pulses; FSM is back in IDLE; a subsequent up tap gives 51.
- Hold db_up, then raise db_down 3 cycles later: only the first step_up occurs, and no further steps until both are released.
- From duty_shadow=100, tap up: with DUTY_WRAP_EN, 0; without it, 100 and pending unchanged. From 0, tap down: wrap gives 100, saturate gives 0.
- Assert period_end in the same cycle as a step (shadow 50→51): duty=50 and pending=1. Then assert reset during REPEAT: all outputs equal the reset values with no step pulse.

Source files
------------

// File: rtl/duty_step_ctrl.sv
// Duty-cycle step sequencer: button edges to single/auto-repeat steps, with the shadow duty committed at PWM period boundaries.
// Optional feature macro DUTY_WRAP_EN: duty wraps at the bounds instead of saturating.
module duty_step_ctrl #(
    parameter int MAX_DUTY   = 100,
    parameter int HOLD_DLY   = 50_000_000,
    parameter int REPEAT_INT = 10_000_000,
    parameter int INIT_DUTY  = 50
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       db_up,
    input  logic       db_down,
    input  logic       period_end,
    output logic [6:0] duty,
    output logic [6:0] duty_shadow,
    output logic       pending,
    output logic       step_up,
    output logic       step_down
);

    localparam int TMR_MAX = (HOLD_DLY > REPEAT_INT) ? HOLD_DLY : REPEAT_INT;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_DLY - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_INT - 1);
    localparam logic [6:0]       MAX_D       = 7'(MAX_DUTY);
    localparam logic [6:0]       INIT_D      = 7'(INIT_DUTY);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    state_t           state, state_nxt;
    logic             db_up_q, db_down_q;
    logic             dir_up, dir_up_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             step_up_nxt, step_down_nxt;
    logic             rise_up, rise_down;
    logic             held, other_rise, tmr_last;
    logic [6:0]       shadow_inc, shadow_dec, shadow_nxt;
    logic             shadow_chg;

    assign rise_up   = db_up & ~db_up_q;
    assign rise_down = db_down & ~db_down_q;

    always_comb begin
        state_nxt     = state;
        dir_up_nxt    = dir_up;
        step_up_nxt   = 1'b0;
        step_down_nxt = 1'b0;
        held          = dir_up ? db_up : db_down;
        other_rise    = dir_up ? rise_down : rise_up;
        tmr_last      = (state == HOLD) ? (timer == HOLD_LAST) : (timer == REPEAT_LAST);

        case (state)
            IDLE: begin
                if (rise_up && rise_down) begin
                    state_nxt = LOCK;
                end else if (rise_up) begin
                    step_up_nxt = 1'b1;
                    dir_up_nxt  = 1'b1;
                    state_nxt   = HOLD;
                end else if (rise_down) begin
                    step_down_nxt = 1'b1;
                    dir_up_nxt    = 1'b0;
                    state_nxt     = HOLD;
                end
            end
            // Release wins over a conflicting press, which wins over a due repeat step
            HOLD, REPEAT: begin
                if (!held) begin
                    state_nxt = IDLE;
                end else if (other_rise) begin
                    state_nxt = LOCK;
                end else if (tmr_last) begin
                    step_up_nxt   = dir_up;
                    step_down_nxt = ~dir_up;
                    state_nxt     = REPEAT;
                end
            end
            LOCK: begin
                if (!db_up && !db_down) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt != state) || step_up_nxt || step_down_nxt) begin
            timer_nxt = '0;
        end else if ((state == HOLD) || (state == REPEAT)) begin
            timer_nxt = timer + 1'b1;
        end else begin
            timer_nxt = '0;
        end
    end

    always_comb begin
`ifdef DUTY_WRAP_EN
        shadow_inc = (duty_shadow >= MAX_D) ? 7'd0 : duty_shadow + 7'd1;
        shadow_dec = (duty_shadow == 7'd0) ? MAX_D : duty_shadow - 7'd1;
`else
        shadow_inc = (duty_shadow >= MAX_D) ? duty_shadow : duty_shadow + 7'd1;
        shadow_dec = (duty_shadow == 7'd0) ? duty_shadow : duty_shadow - 7'd1;
`endif
        shadow_nxt = duty_shadow;
        if (step_up_nxt) begin
            shadow_nxt = shadow_inc;
        end else if (step_down_nxt) begin
            shadow_nxt = shadow_dec;
        end
        shadow_chg = (shadow_nxt != duty_shadow);
    end

    // Commit takes the pre-step shadow; a changing step keeps pending set even on period_end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            dir_up      <= 1'b0;
            timer       <= '0;
            db_up_q     <= 1'b0;
            db_down_q   <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            duty_shadow <= INIT_D;
            duty        <= INIT_D;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_up      <= dir_up_nxt;
            timer       <= timer_nxt;
            db_up_q     <= db_up;
            db_down_q   <= db_down;
            step_up     <= step_up_nxt;
            step_down   <= step_down_nxt;
            duty_shadow <= shadow_nxt;
            if (period_end) begin
                duty <= duty_shadow;
            end
            if (shadow_chg) begin
                pending <= 1'b1;
            end else if (period_end) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_duty_step_ctrl.sv
// Self-checking bench for duty_step_ctrl: fixed vector table, directed corner sequences and random stimulus vs a press-age model.
module tb_duty_step_ctrl;

    localparam int MAX_DUTY   = 100;
    localparam int HOLD_DLY   = 8;
    localparam int REPEAT_INT = 3;
    localparam int INIT_DUTY  = 50;
`ifdef DUTY_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       db_up      = 1'b0;
    logic       db_down    = 1'b0;
    logic       period_end = 1'b0;
    logic [6:0] duty, duty_shadow;
    logic       pending, step_up, step_down;

    int vec_count   = 0;
    int miscompares = 0;

    // Reference model: a press is described by its direction and its age in cycles
    int m_duty, m_shadow, m_dir, m_age;
    bit m_pending, m_su, m_sd, m_prev_up, m_prev_down, m_locked;

    typedef struct {
        bit       up, down, pe;
        bit       e_su, e_sd;
        bit [6:0] e_shadow;
        bit       e_pend;
        bit [6:0] e_duty;
    } vec_t;

    vec_t tbl[9];

    duty_step_ctrl #(
        .MAX_DUTY  (MAX_DUTY),
        .HOLD_DLY  (HOLD_DLY),
        .REPEAT_INT(REPEAT_INT),
        .INIT_DUTY (INIT_DUTY)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .db_up      (db_up),
        .db_down    (db_down),
        .period_end (period_end),
        .duty       (duty),
        .duty_shadow(duty_shadow),
        .pending    (pending),
        .step_up    (step_up),
        .step_down  (step_down)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int bump(int v, bit up);
        if (up) return (v == MAX_DUTY) ? (WRAP ? 0 : MAX_DUTY) : v + 1;
        else    return (v == 0) ? (WRAP ? MAX_DUTY : 0) : v - 1;
    endfunction

    task automatic model_reset();
        m_duty = INIT_DUTY; m_shadow = INIT_DUTY; m_pending = 0;
        m_su = 0; m_sd = 0; m_prev_up = 0; m_prev_down = 0;
        m_locked = 0; m_dir = 0; m_age = 0;
    endtask

    task automatic model_cycle(bit up, bit down, bit pe);
        bit ru, rd, do_up, do_dn, held, other;
        int nshadow;
        ru = up & ~m_prev_up;
        rd = down & ~m_prev_down;
        do_up = 0; do_dn = 0;
        if (m_locked) begin
            if (!up && !down) m_locked = 0;
        end else if (m_dir == 0) begin
            if (ru && rd) m_locked = 1;
            else if (ru) begin do_up = 1; m_dir = 1; m_age = 0; end
            else if (rd) begin do_dn = 1; m_dir = 2; m_age = 0; end
        end else begin
            m_age++;
            held  = (m_dir == 1) ? up : down;
            other = (m_dir == 1) ? rd : ru;
            if (!held) m_dir = 0;
            else if (other) begin m_dir = 0; m_locked = 1; end
            else if (m_age >= HOLD_DLY && ((m_age - HOLD_DLY) % REPEAT_INT) == 0) begin
                do_up = (m_dir == 1);
                do_dn = (m_dir == 2);
            end
        end
        nshadow = m_shadow;
        if (do_up) nshadow = bump(m_shadow, 1);
        else if (do_dn) nshadow = bump(m_shadow, 0);
        if (pe) m_duty = m_shadow;
        if (nshadow != m_shadow) m_pending = 1;
        else if (pe) m_pending = 0;
        m_shadow = nshadow;
        m_su = do_up; m_sd = do_dn;
        m_prev_up = up; m_prev_down = down;
    endtask

    task automatic check_field(string name, int act, int req);
        vec_count++;
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic checkOutput();
        vec_count++;
        if (step_up !== m_su || step_down !== m_sd || duty_shadow !== 7'(m_shadow) ||
            pending !== m_pending || duty !== 7'(m_duty)) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t: got su=%b sd=%b shadow=%0d pend=%b duty=%0d, want su=%b sd=%b shadow=%0d pend=%b duty=%0d",
                     $time, step_up, step_down, duty_shadow, pending, duty,
                     m_su, m_sd, m_shadow, m_pending, m_duty);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic applyStimulus(bit up, bit down, bit pe);
        db_up = up; db_down = down; period_end = pe;
        model_cycle(up, down, pe);
        @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput();
    endtask

    task automatic do_reset();
        sys_rst_n = 0; db_up = 0; db_down = 0; period_end = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        model_reset();
        sys_rst_n = 1;
    endtask

    task automatic drive_to(int target);
        bit go_up;
        go_up = (m_shadow < target);
        for (int i = 0; i < 2000 && m_shadow != target; i++) applyStimulus(go_up, !go_up, 0);
        applyStimulus(0, 0, 0);
        check_field("drive_to", duty_shadow, target);
    endtask

    initial begin
        int pos[$];
        int n_up, n_dn;
        bit ru, rd;

        tbl[0] = '{1, 0, 0, 1, 0, 7'd51, 1, 7'd50};
        tbl[1] = '{1, 0, 0, 0, 0, 7'd51, 1, 7'd50};
        tbl[2] = '{1, 0, 0, 0, 0, 7'd51, 1, 7'd50};
        tbl[3] = '{1, 0, 0, 0, 0, 7'd51, 1, 7'd50};
        tbl[4] = '{0, 0, 0, 0, 0, 7'd51, 1, 7'd50};
        tbl[5] = '{0, 0, 1, 0, 0, 7'd51, 0, 7'd51};
        tbl[6] = '{0, 1, 1, 0, 1, 7'd50, 1, 7'd51};
        tbl[7] = '{0, 0, 0, 0, 0, 7'd50, 1, 7'd51};
        tbl[8] = '{0, 0, 1, 0, 0, 7'd50, 0, 7'd50};

        do_reset();
        check_field("reset_duty", duty, 50);
        check_field("reset_shadow", duty_shadow, 50);
        check_field("reset_flags", {pending, step_up, step_down}, 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].up, tbl[i].down, tbl[i].pe);
            check_field($sformatf("table[%0d]", i),
                        int'({step_up, step_down, duty_shadow, pending, duty}),
                        int'({tbl[i].e_su, tbl[i].e_sd, tbl[i].e_shadow, tbl[i].e_pend, tbl[i].e_duty}));
        end

        // Hold down for 20 cycles
        do_reset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0);
            if (step_down) pos.push_back(i + 1);
        end
        n_dn = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0);
            n_dn += int'(step_down);
        end
        check_field("hold_steps", pos.size(), 5);
        if (pos.size() == 5) begin
            check_field("hold_pos0", pos[0], 1);
            check_field("hold_pos1", pos[1], 9);
            check_field("hold_pos2", pos[2], 12);
            check_field("hold_pos3", pos[3], 15);
            check_field("hold_pos4", pos[4], 18);
        end
        check_field("after_release", n_dn, 0);
        check_field("hold_shadow", duty_shadow, 45);

        // Simultaneous press locks out
        do_reset();
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0);
            n_up += int'(step_up); n_dn += int'(step_down);
        end
        applyStimulus(0, 0, 0);
        check_field("lock_pulses", n_up + n_dn, 0);
        applyStimulus(1, 0, 0);
        check_field("lock_then_tap", duty_shadow, 51);
        applyStimulus(0, 0, 0);

        // Conflicting press during hold
        do_reset();
        n_up = 0; n_dn = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0);
            n_up += int'(step_up);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0);
            n_up += int'(step_up); n_dn += int'(step_down);
        end
        applyStimulus(0, 0, 0);
        check_field("conflict_up", n_up, 1);
        check_field("conflict_down", n_dn, 0);

        // Bounds
        drive_to(MAX_DUTY);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 0);
        check_field("up_at_max_stepup", step_up, 1);
        check_field("up_at_max_shadow", duty_shadow, WRAP ? 0 : MAX_DUTY);
        check_field("up_at_max_pending", pending, WRAP ? 1 : 0);
        applyStimulus(0, 0, 0);
        drive_to(0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 1, 0);
        check_field("down_at_0_shadow", duty_shadow, WRAP ? MAX_DUTY : 0);
        check_field("down_at_0_pending", pending, WRAP ? 1 : 0);
        applyStimulus(0, 0, 0);

        // Commit coincident with a step, then async reset during auto-repeat
        do_reset();
        applyStimulus(1, 0, 1);
        check_field("same_cycle_duty", duty, 50);
        check_field("same_cycle_pending", pending, 1);
        check_field("same_cycle_shadow", duty_shadow, 51);
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0);
        #2 sys_rst_n = 0;
        #1;
        check_field("async_duty", duty, 50);
        check_field("async_shadow", duty_shadow, 50);
        check_field("async_flags", {pending, step_up, step_down}, 0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_field("in_reset_step", step_up, 0);
        db_up = 0;
        model_reset();
        sys_rst_n = 1;

        // Random traffic
        ru = 0; rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) ru = !ru;
            if ($urandom_range(0, 11) == 0) rd = !rd;
            applyStimulus(ru, rd, $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
